command_issuer: RTL and testbench
=================================

Name: command_issuer

Overview:
- Host-side command source for the ALU controller; it drives the controller's 12-bit command and run (syscall) inputs.
- The host loads opaque 12-bit command words into an internal FIFO, then pulses start.
- The block pops one word at a time and presents it on command, with a one-cycle run strobe.
- Consecutive strobes are spaced so the controller and its operand registers can complete each operation.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CMD_W, 12, command word width; matches the controller command input.
- GAP, 4, cycles from one run strobe to the next (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  host push strobe.
- wr_cmd  input  CMD_W  command word to push.
- start  input  1  one-cycle pulse to begin draining the FIFO.
- command  output  CMD_W  command word presented to the controller.
- run  output  1  one-cycle issue strobe to the controller's syscall input.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle pulse when the FIFO has drained.
- full  output  1  FIFO count == DEPTH.
- empty  output  1  FIFO count == 0.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  one-cycle pulse when a push is dropped.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: command=0, run=0, busy=0, done=0, overflow=0, count=0, empty=1, full=0, state=IDLE, read/write pointers=0, gap counter=0.
- Reset mid-issue: the FIFO contents are discarded and the block returns to IDLE.
- FIFO: circular buffer with pointers that wrap modulo DEPTH.
- full, empty and count are registered and reflect the state after each edge.
- Push is accepted when wr_en and (!full or a pop happens in the same cycle).
- A rejected push drops the word and pulses overflow on the next cycle.
- Simultaneous push and pop leaves count unchanged; both pointers advance.

FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - start && !empty -> ISSUE.
  - start && empty -> stays IDLE and pulses done one cycle later (empty-run completion).
  - start while busy is ignored.
- ISSUE (exactly one cycle):
  - Pop the head; on the next edge, command <= head word and run <= 1 for exactly that one cycle.
  - Load the gap counter with GAP-1; -> WAIT.
- WAIT:
  - command holds its last value and run=0; the counter decrements each cycle.
  - On counter==1: if the FIFO is non-empty -> ISSUE, else -> IDLE and pulse done.
  - The next run therefore rises exactly GAP cycles after the previous one.
- Words pushed during WAIT are issued in the same run if they arrive before the empty check.
- command is not cleared after done; it holds the last word issued.
- Latency: start at edge t -> run high in cycle t+2 with the oldest FIFO word on command.
- Ordering is strictly FIFO; no reordering and no word is ever duplicated.
- Every registered output, including the FSM state, resets asynchronously.

Decomposition:
- Shared package alu_pkg holds:
  - CMD_W;
  - typedef issuer_state_t (enum IDLE, ISSUE, WAIT);
  - the typedef logic [CMD_W-1:0] cmd_t.
- One sub-module is natural: cmd_fifo, which is the synchronous FIFO with push, pop, full, empty and count.
- The FSM, gap counter and output registers stay in command_issuer.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT with 3 words queued -> all outputs at reset values immediately; count=0 after release; no run pulses.
- Basic drain: push 12'h0A1, 12'h1B2, 12'h2C3, then pulse start -> run rises at start+2, start+2+GAP and start+2+2*GAP.
  - command equals 0A1, 1B2, 2C3 in those cycles.
  - done pulses once, busy falls, count=0.
- Full/overflow: push 9 words with DEPTH=8 -> full=1 after the 8th push.
  - The 9th word is dropped and overflow pulses once.
  - The drain issues exactly the first 8 words, in order.
- Push at full with simultaneous pop: fill to 8, start, and push 12'hFFF in the ISSUE pop cycle -> accepted, count stays 8, no overflow, 12'hFFF issued last.
- Late push: start with 1 word and push 12'h555 during WAIT -> issued GAP cycles after the first word; a single done after it.
- Empty start: start with an empty FIFO -> no run pulse, done pulses one cycle later, busy stays 0.
  - A start pulsed while busy has no effect on the issue sequence.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the host-side command issuer that feeds the
// ALU controller.
//   CMD_W          width of a controller command word
//   cmd_t          one command word
//   issuer_state_t issue sequencer states
package alu_pkg;

  localparam int CMD_W = 12;

  typedef logic [CMD_W-1:0] cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous circular-buffer FIFO for command words.
// Ports:
//   clk, rst_n  clock, async active-low reset (pointers/flags only)
//   push, din   push request and data; taken if not full or popping now
//   pop         pop request; ignored when empty
//   head        word at the read pointer (valid when !empty)
//   drop        push request rejected this cycle
//   full, empty, count  registered occupancy after each edge
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 12,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          drop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;
  logic [CW-1:0] count_nxt;

  // A pop in the same cycle frees a slot, so a push at full still fits.
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign drop      = push && !push_ok;
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign head      = mem[rd_ptr];

  // Storage carries no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/command_issuer.sv
// command_issuer: drains a host-loaded FIFO of command words into the ALU
// controller, one word per run strobe, strobes spaced GAP cycles apart.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   wr_en, wr_cmd   host push
//   start           begin draining (ignored while busy)
//   command, run    word presented to the controller and its 1-cycle strobe
//   busy            sequencer not idle
//   done            1-cycle pulse when a drain (possibly empty) completes
//   full, empty, count  FIFO occupancy
//   overflow        1-cycle pulse the cycle after a push was dropped
module command_issuer #(
  parameter int DEPTH = 8,
  parameter int CMD_W = alu_pkg::CMD_W,
  parameter int GAP   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [CMD_W-1:0]       wr_cmd,
  input  logic                   start,
  output logic [CMD_W-1:0]       command,
  output logic                   run,
  output logic                   busy,
  output logic                   done,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  import alu_pkg::*;

  localparam int GW = $clog2(GAP + 1);

  issuer_state_t    state, nxt;
  logic [GW-1:0]    gap_cnt;
  logic             pop, drop, gap_end;
  logic [CMD_W-1:0] head;

  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .din   (wr_cmd),
    .pop   (pop),
    .head  (head),
    .drop  (drop),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign gap_end = (gap_cnt == GW'(1));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // The empty check at gap_end sees the registered flag, so a word pushed
  // up to one cycle before it still joins the current drain.
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      IDLE:  if (start && !empty) nxt = ISSUE;
      ISSUE: begin
        pop = 1'b1;
        nxt = WAIT;
      end
      WAIT:  if (gap_end) nxt = empty ? IDLE : ISSUE;
      default: nxt = IDLE;
    endcase
  end

  // Loading GAP-1 as run rises and leaving WAIT at 1 puts the next
  // ISSUE GAP-1 cycles later, so strobes are exactly GAP apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      command  <= '0;
      run      <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      run      <= (state == ISSUE);
      overflow <= drop;
      done     <= (state == IDLE && start && empty) ||
                  (state == WAIT && gap_end && empty);
      if (state == ISSUE) begin
        command <= head;
        gap_cnt <= GW'(GAP - 1);
      end else if (state == WAIT && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_command_issuer.sv
module tb_command_issuer;

  localparam int DEPTH = 8;
  localparam int CMD_W = 12;
  localparam int GAP   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en, start;
  logic [CMD_W-1:0] wr_cmd;
  logic [CMD_W-1:0] command;
  logic             run, busy, done, full, empty, overflow;
  logic [CW-1:0]    count;

  command_issuer #(.DEPTH(DEPTH), .CMD_W(CMD_W), .GAP(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_cmd   (wr_cmd),
    .start    (start),
    .command  (command),
    .run      (run),
    .busy     (busy),
    .done     (done),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int runs_seen, dones_seen, ovf_seen;

  // Reference: a queue of pending words plus the cycle times of the next
  // pop and next empty check of an active drain.
  logic [CMD_W-1:0] q[$];
  bit               active;
  int               pop_at, check_at;
  logic [CMD_W-1:0] e_cmd;
  bit               e_run, e_done, e_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    active = 0; pop_at = -1; check_at = -1;
    e_cmd = '0; e_run = 0; e_done = 0; e_ovf = 0;
  endtask

  task automatic model_step(input bit we, input logic [CMD_W-1:0] wd, input bit st);
    bit was_active, pop_now, chk_now, accept;
    was_active = active;
    pop_now = active && (cyc == pop_at);
    chk_now = active && (cyc == check_at);
    accept  = we && (q.size() < DEPTH || pop_now);
    e_run  = pop_now;
    e_ovf  = we && !accept;
    e_done = 0;
    if (chk_now) begin
      if (q.size() != 0) pop_at = cyc + 1;
      else begin active = 0; e_done = 1; end
    end
    if (!was_active && st) begin
      if (q.size() == 0) e_done = 1;
      else begin active = 1; pop_at = cyc + 1; end
    end
    if (pop_now) begin
      e_cmd    = q.pop_front();
      check_at = cyc + GAP - 1;
    end
    if (accept) q.push_back(wd);
  endtask

  task automatic compare();
    chk("run",      run,      e_run);
    chk("command",  command,  e_cmd);
    chk("done",     done,     e_done);
    chk("overflow", overflow, e_ovf);
    chk("busy",     busy,     active);
    chk("count",    count,    q.size());
    chk("full",     full,     q.size() == DEPTH);
    chk("empty",    empty,    q.size() == 0);
    if (run) runs_seen++;
    if (done) dones_seen++;
    if (overflow) ovf_seen++;
  endtask

  task automatic step(input bit we, input logic [CMD_W-1:0] wd, input bit st);
    wr_en = we; wr_cmd = wd; start = st;
    @(posedge clk);
    model_step(we, wd, st);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0);
  endtask

  // Bounded by cycle budget, driven off the model, never the DUT.
  task automatic drain();
    for (int i = 0; i < 200 && active; i++) step(0, '0, 0);
    step(0, '0, 0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_command"}, command, 0);
    chk({tag, "_run"},     run,     0);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_done"},    done,    0);
    chk({tag, "_ovf"},     overflow, 0);
    chk({tag, "_count"},   count,   0);
    chk({tag, "_empty"},   empty,   1);
    chk({tag, "_full"},    full,    0);
  endtask

  task automatic clr_stats();
    runs_seen = 0; dones_seen = 0; ovf_seen = 0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 0; wr_cmd = '0; start = 0;
    model_reset();
    #12;
    reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic drain
    clr_stats();
    step(1, 12'h0A1, 0); step(1, 12'h1B2, 0); step(1, 12'h2C3, 0);
    step(0, '0, 1);
    drain();
    chk("basic_runs",  runs_seen,  3);
    chk("basic_dones", dones_seen, 1);

    // Full / overflow: ninth word dropped
    clr_stats();
    for (int i = 0; i < 9; i++) step(1, CMD_W'(12'h300 + i), 0);
    chk("ovf_pulses", ovf_seen, 1);
    step(0, '0, 1);
    drain();
    chk("full_runs", runs_seen, 8);

    // Push at full in the ISSUE pop cycle is accepted
    clr_stats();
    for (int i = 0; i < 8; i++) step(1, CMD_W'(12'h400 + i), 0);
    step(0, '0, 1);
    step(1, 12'hFFF, 0);
    chk("popfull_count", count, 8);
    drain();
    chk("popfull_ovf",  ovf_seen, 0);
    chk("popfull_runs", runs_seen, 9);
    chk("popfull_last", command, 12'hFFF);

    // Late push during WAIT joins the same drain
    clr_stats();
    step(1, 12'h123, 0);
    step(0, '0, 1);
    idle(1);
    step(1, 12'h555, 0);
    drain();
    chk("late_runs",  runs_seen, 2);
    chk("late_dones", dones_seen, 1);
    chk("late_last",  command, 12'h555);

    // Empty start, then starts while busy
    clr_stats();
    step(0, '0, 1);
    idle(2);
    chk("empty_dones", dones_seen, 1);
    chk("empty_runs",  runs_seen, 0);
    step(1, 12'h0AA, 0); step(1, 12'h0BB, 0);
    step(0, '0, 1);
    for (int i = 0; i < 6; i++) step(0, '0, 1);
    drain();
    chk("busystart_runs", runs_seen, 2);

    // Reset in WAIT with 3 words still queued
    for (int i = 0; i < 4; i++) step(1, CMD_W'(12'h600 + i), 0);
    step(0, '0, 1);
    idle(2);
    #2 rst_n = 1'b0;
    #1 reset_vals("midrst");
    clr_stats();
    repeat (2) @(negedge clk);
    chk("midrst_runs", runs_seen + int'(run), 0);
    rst_n = 1'b1;
    model_reset();
    idle(3);
    chk("midrst_count", count, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 3) == 0, CMD_W'($urandom), ($urandom % 10) == 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
